mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Memory-access pipeline stage of the 5-stage LoongArch core, directly downstream of the execute stage.
//  Registers the 76-bit execute-to-memory bus and collects the synchronous data-SRAM read data.
//  Extracts and sign/zero-extends byte/half/word load data, selects the final writeback value,
//  and hands it to writeback under valid/allow-in flow control. Also drives the ID forwarding and hazard taps.
// PARAMETERS
//  IN_W    76  width of EX_to_ME_Bus
//  OUT_W   70  width of ME_to_WB_Bus = {pc[31:0], final_result[31:0], gr_we, dest[4:0]}
// PORTS
//  clk              in   1      single clock, rising edge
//  reset            in   1      asynchronous, active-high
//  EX_to_ME_Valid   in   1      EX holds a completed instruction
//  EX_to_ME_Bus     in   IN_W   {ld_signed,is_byte,is_half,off[1:0]}[75:71], pc[70:39], alu_result[38:7], res_from_mem[6], gr_we[5], dest[4:0]
//  ME_Allow_in      out  1      stage can accept a new instruction this cycle
//  data_sram_rdata  in   32     read data; valid the cycle after EX presented the address
//  WB_Allow_in      in   1      writeback can accept
//  ME_to_WB_Valid   out  1      instruction in ME is ready to transfer
//  ME_to_WB_Bus     out  OUT_W  see OUT_W
//  ME_dest          out  5      dest & {5{ME_Valid & gr_we}}; 0 when no write pending
//  ME_Forward_Res   out  32     final_result (load data or alu_result)
//  ME_to_ID_Ld_op   out  1      ME_Valid & res_from_mem
// BEHAVIOUR
//  - Flow control: ME_ReadyGo = 1.
//    ME_Allow_in = !ME_Valid | (ME_ReadyGo & WB_Allow_in).
//    ME_to_WB_Valid = ME_Valid & ME_ReadyGo.
//  - On posedge, if ME_Allow_in: ME_Valid <= EX_to_ME_Valid.
//    If also EX_to_ME_Valid: latch EX_to_ME_Bus into payload registers.
//    Otherwise hold everything.
//  - Async reset: ME_Valid=0, payload=0, rd_held=0, rd_buf=0.
//    Hence ME_to_WB_Valid=0, ME_Allow_in=1, ME_dest=0, ME_to_ID_Ld_op=0, ME_to_WB_Bus=0.
//    Reset asserted mid-stall discards the instruction; no partial transfer.
//  - Read-data capture FSM (per instruction), state in rd_held:
//    FRESH (rd_held=0): load_word = data_sram_rdata.
//      If ME_Valid & !(WB_Allow_in): capture rd_buf <= data_sram_rdata, go to HELD.
//    HELD (rd_held=1): load_word = rd_buf. SRAM changes are ignored.
//    Any new-instruction latch (ME_Allow_in & EX_to_ME_Valid) forces FRESH, overriding the capture.
//    An allow-in with no new valid input also clears to FRESH.
//  - Load extraction, where off = addr[1:0]:
//    is_byte: b = load_word[8*off +: 8]; result = ld_signed ? {{24{b[7]}},b} : {24'b0,b}.
//    is_half: h = off[1] ? load_word[31:16] : load_word[15:0]; extend as above using h[15]; off[0] ignored.
//    Otherwise: full word.
//  - final_result = res_from_mem ? extracted load : alu_result. Purely combinational from the registers.
//    Zero added latency: an instruction leaves the cycle after entry if WB_Allow_in=1.
//  - Simultaneous transfer-out and transfer-in in the same cycle is supported.
//    Back-to-back throughput is 1 instruction/cycle.
//  - When ME_Valid=0, ME_dest/Ld_op outputs are 0. Bus contents are don't-care but stable.
// TESTING
//  1. reset pulse mid-cycle (async) with ME_Valid=1 -> ME_to_WB_Valid=0 immediately, ME_Allow_in=1, ME_dest=0.
//  2. ld.b, signed, off=3, rdata=32'h80FF_1234, WB_Allow_in=1 -> final_result=32'hFFFF_FF80 next cycle.
//     Same with unsigned -> 32'h0000_0080.
//  3. ld.hu, off=2, rdata=32'hBEEF_0001 -> 32'h0000_BEEF.
//     ld.h, off=0 -> 32'h0000_0001.
//  4. Load in ME, WB_Allow_in=0 for 3 cycles, rdata changes to 32'hDEAD_DEAD after cycle 1
//     -> output holds the originally captured word.
//     ME_Allow_in=0 throughout; transfer occurs on the cycle WB_Allow_in=1.
//  5. Four back-to-back ALU ops (res_from_mem=0, gr_we=1, dest=1..4), WB_Allow_in=1
//     -> four consecutive ME_to_WB_Valid cycles in order, final_result=alu_result, ME_dest=1,2,3,4.
//  6. Store (gr_we=0, res_from_mem=0) -> ME_dest=0, ME_to_ID_Ld_op=0, bus gr_we=0.

Source files
------------

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - LoongArch memory-access pipeline stage (EX->ME->WB)
//
// Registers the execute-to-memory bus, reads the synchronous data-SRAM
// result, extracts sign/zero-extended byte/half/word load data and hands the
// final writeback value to WB under valid/allow-in handshaking.
//
// Ports:
//   clk, reset        clock (rising edge), asynchronous active-high reset
//   EX_to_ME_Valid/Bus  incoming instruction and its 76-bit payload
//   ME_Allow_in       stage can accept a new instruction this cycle
//   data_sram_rdata   SRAM read data, valid in the instruction's first ME cycle
//   WB_Allow_in       writeback can accept
//   ME_to_WB_Valid/Bus  outgoing {pc, final_result, gr_we, dest}
//   ME_dest           pending destination register, 0 when none
//   ME_Forward_Res    final_result for ID forwarding
//   ME_to_ID_Ld_op    a load sits in ME (load-use hazard tap)

module mem_stage #(
    parameter int IN_W  = 76,
    parameter int OUT_W = 70
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             EX_to_ME_Valid,
    input  logic [IN_W-1:0]  EX_to_ME_Bus,
    output logic             ME_Allow_in,
    input  logic [31:0]      data_sram_rdata,
    input  logic             WB_Allow_in,
    output logic             ME_to_WB_Valid,
    output logic [OUT_W-1:0] ME_to_WB_Bus,
    output logic [4:0]       ME_dest,
    output logic [31:0]      ME_Forward_Res,
    output logic             ME_to_ID_Ld_op
);

    typedef enum logic {
        RD_FRESH = 1'b0,
        RD_HELD  = 1'b1
    } rd_state_e;

    logic            me_valid_q;
    logic [IN_W-1:0] payload_q;
    rd_state_e       rd_state_q, rd_state_d;
    logic [31:0]     rd_buf_q, rd_buf_d;

    logic        me_ready_go;
    logic        ld_signed, is_byte, is_half, res_from_mem, gr_we;
    logic [1:0]  off;
    logic [31:0] pc, alu_result, load_word, load_result, final_result;
    logic [4:0]  dest;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;

    assign ld_signed    = payload_q[75];
    assign is_byte      = payload_q[74];
    assign is_half      = payload_q[73];
    assign off          = payload_q[72:71];
    assign pc           = payload_q[70:39];
    assign alu_result   = payload_q[38:7];
    assign res_from_mem = payload_q[6];
    assign gr_we        = payload_q[5];
    assign dest         = payload_q[4:0];

    assign me_ready_go    = 1'b1;
    assign ME_Allow_in    = !me_valid_q || (me_ready_go && WB_Allow_in);
    assign ME_to_WB_Valid = me_valid_q && me_ready_go;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            me_valid_q <= 1'b0;
            payload_q  <= '0;
        end else if (ME_Allow_in) begin
            me_valid_q <= EX_to_ME_Valid;
            if (EX_to_ME_Valid) begin
                payload_q <= EX_to_ME_Bus;
            end
        end
    end

    // The SRAM only presents the read word during the instruction's first
    // cycle in ME; if WB stalls us, snapshot it so later SRAM traffic from
    // younger instructions cannot corrupt the result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_state_q <= RD_FRESH;
            rd_buf_q   <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_buf_q   <= rd_buf_d;
        end
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rd_buf_d   = rd_buf_q;
        if (ME_Allow_in) begin
            // Either a new instruction enters or the stage empties.
            rd_state_d = RD_FRESH;
        end else if (rd_state_q == RD_FRESH && me_valid_q && !WB_Allow_in) begin
            rd_state_d = RD_HELD;
            rd_buf_d   = data_sram_rdata;
        end
    end

    assign load_word = (rd_state_q == RD_HELD) ? rd_buf_q : data_sram_rdata;

    always_comb begin
        ld_b = 8'h00;
        case (off)
            2'd0: ld_b = load_word[7:0];
            2'd1: ld_b = load_word[15:8];
            2'd2: ld_b = load_word[23:16];
            2'd3: ld_b = load_word[31:24];
            default: ld_b = 8'h00;
        endcase
    end

    // Halfword loads are aligned; off[0] is ignored.
    assign ld_h = off[1] ? load_word[31:16] : load_word[15:0];

    always_comb begin
        load_result = load_word;
        if (is_byte) begin
            load_result = {{24{ld_signed & ld_b[7]}}, ld_b};
        end else if (is_half) begin
            load_result = {{16{ld_signed & ld_h[15]}}, ld_h};
        end
    end

    assign final_result = res_from_mem ? load_result : alu_result;

    assign ME_to_WB_Bus   = {pc, final_result, gr_we, dest};
    assign ME_Forward_Res = final_result;
    assign ME_dest        = dest & {5{me_valid_q & gr_we}};
    assign ME_to_ID_Ld_op = me_valid_q & res_from_mem;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage

module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        EX_to_ME_Valid;
    logic [75:0] EX_to_ME_Bus;
    logic        ME_Allow_in;
    logic [31:0] data_sram_rdata;
    logic        WB_Allow_in;
    logic        ME_to_WB_Valid;
    logic [69:0] ME_to_WB_Bus;
    logic [4:0]  ME_dest;
    logic [31:0] ME_Forward_Res;
    logic        ME_to_ID_Ld_op;

    int total = 0;
    int bad   = 0;

    mem_stage #(.IN_W(76), .OUT_W(70)) dut (
        .clk             (clk),
        .reset           (reset),
        .EX_to_ME_Valid  (EX_to_ME_Valid),
        .EX_to_ME_Bus    (EX_to_ME_Bus),
        .ME_Allow_in     (ME_Allow_in),
        .data_sram_rdata (data_sram_rdata),
        .WB_Allow_in     (WB_Allow_in),
        .ME_to_WB_Valid  (ME_to_WB_Valid),
        .ME_to_WB_Bus    (ME_to_WB_Bus),
        .ME_dest         (ME_dest),
        .ME_Forward_Res  (ME_Forward_Res),
        .ME_to_ID_Ld_op  (ME_to_ID_Ld_op)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [69:0] act, input logic [69:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [75:0] mk(input logic s, input logic b, input logic h,
                                       input logic [1:0] off, input logic [31:0] pc,
                                       input logic [31:0] alu, input logic rfm,
                                       input logic we, input logic [4:0] dst);
        return {s, b, h, off, pc, alu, rfm, we, dst};
    endfunction

    // Expected writeback value computed from the instruction fields with
    // plain shift/mask arithmetic.
    function automatic logic [31:0] exp_result(input logic [75:0] bus, input logic [31:0] word);
        logic [31:0] v;
        int          off;
        logic [75:0] t;
        t   = bus;
        off = int'(t[72:71]);
        if (!t[6]) return t[38:7];
        if (t[74]) begin
            v = (word >> (8 * off)) & 32'h0000_00FF;
            if (t[75] && v >= 32'd128) v = v | 32'hFFFF_FF00;
        end else if (t[73]) begin
            v = (word >> ((off >= 2) ? 16 : 0)) & 32'h0000_FFFF;
            if (t[75] && v >= 32'd32768) v = v | 32'hFFFF_0000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    // Model: one slot holding the instruction in ME; the load word is
    // whatever the SRAM showed during that instruction's first cycle.
    logic        m_valid;
    logic        m_first;
    logic [75:0] m_bus;
    logic [31:0] m_word = 32'h0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_first <= 1'b0;
            m_bus   <= '0;
        end else if (!m_valid || WB_Allow_in) begin
            m_valid <= EX_to_ME_Valid;
            m_first <= EX_to_ME_Valid;
            if (EX_to_ME_Valid) m_bus <= EX_to_ME_Bus;
        end else begin
            m_first <= 1'b0;
        end
    end

    always @(negedge clk) begin
        logic [31:0] r;
        logic [75:0] b;
        if (!reset) begin
            b = m_bus;
            if (m_valid && m_first) m_word = data_sram_rdata;
            chk("wb_valid", 70'(ME_to_WB_Valid), 70'(m_valid));
            chk("allow_in", 70'(ME_Allow_in), 70'(!m_valid || WB_Allow_in));
            if (m_valid) begin
                r = exp_result(b, m_word);
                chk("wb_bus", ME_to_WB_Bus, {b[70:39], r, b[5], b[4:0]});
                chk("fwd_res", 70'(ME_Forward_Res), 70'(r));
                chk("me_dest", 70'(ME_dest), 70'(b[5] ? b[4:0] : 5'd0));
                chk("ld_op", 70'(ME_to_ID_Ld_op), 70'(b[6]));
            end else begin
                chk("me_dest_idle", 70'(ME_dest), 70'd0);
                chk("ld_op_idle", 70'(ME_to_ID_Ld_op), 70'd0);
            end
        end
    end

    // Inputs change 1 time unit after a rising edge; literal checks happen
    // 3 units later, well before the next edge.
    task automatic drive(input logic ev, input logic [75:0] b, input logic wba, input logic [31:0] rd);
        EX_to_ME_Valid  = ev;
        EX_to_ME_Bus    = b;
        WB_Allow_in     = wba;
        data_sram_rdata = rd;
        #3;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset           = 1'b1;
        EX_to_ME_Valid  = 1'b0;
        EX_to_ME_Bus    = '0;
        WB_Allow_in     = 1'b1;
        data_sram_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #3;
        chk("rst_valid", 70'(ME_to_WB_Valid), 70'd0);
        chk("rst_allow", 70'(ME_Allow_in), 70'd1);
        chk("rst_dest", 70'(ME_dest), 70'd0);
        chk("rst_bus", ME_to_WB_Bus, 70'd0);
        tick;

        // Byte and halfword extraction
        drive(1, mk(1, 1, 0, 2'd3, 32'h1C00_0000, 32'h0000_1003, 1, 1, 5'd3), 1, 32'h0);
        tick;
        drive(1, mk(0, 1, 0, 2'd3, 32'h1C00_0004, 32'h0000_1003, 1, 1, 5'd4), 1, 32'h80FF_1234);
        chk("ld_b_s", 70'(ME_Forward_Res), 70'h0_FFFF_FF80);
        tick;
        drive(1, mk(0, 0, 1, 2'd2, 32'h1C00_0008, 32'h0000_2002, 1, 1, 5'd5), 1, 32'h80FF_1234);
        chk("ld_bu", 70'(ME_Forward_Res), 70'h0_0000_0080);
        tick;
        drive(1, mk(1, 0, 1, 2'd0, 32'h1C00_000C, 32'h0000_2000, 1, 1, 5'd6), 1, 32'hBEEF_0001);
        chk("ld_hu", 70'(ME_Forward_Res), 70'h0_0000_BEEF);
        tick;
        drive(0, '0, 1, 32'hBEEF_0001);
        chk("ld_h", 70'(ME_Forward_Res), 70'h0_0000_0001);
        tick;

        // Stalled load keeps its original word while the SRAM changes
        drive(1, mk(0, 0, 0, 2'd0, 32'h1C00_0010, 32'h0000_3000, 1, 1, 5'd9), 1, 32'h0);
        tick;
        drive(1, mk(0, 0, 0, 2'd0, 32'h1C00_0014, 32'h0000_00AA, 0, 1, 5'd10), 0, 32'h1234_5678);
        chk("stall_c1", 70'(ME_Forward_Res), 70'h0_1234_5678);
        chk("stall_allow1", 70'(ME_Allow_in), 70'd0);
        tick;
        drive(1, mk(0, 0, 0, 2'd0, 32'h1C00_0014, 32'h0000_00AA, 0, 1, 5'd10), 0, 32'hDEAD_DEAD);
        chk("stall_c2", 70'(ME_Forward_Res), 70'h0_1234_5678);
        chk("stall_allow2", 70'(ME_Allow_in), 70'd0);
        tick;
        drive(1, mk(0, 0, 0, 2'd0, 32'h1C00_0014, 32'h0000_00AA, 0, 1, 5'd10), 0, 32'hDEAD_DEAD);
        chk("stall_c3", 70'(ME_Forward_Res), 70'h0_1234_5678);
        tick;
        drive(1, mk(0, 0, 0, 2'd0, 32'h1C00_0014, 32'h0000_00AA, 0, 1, 5'd10), 1, 32'hDEAD_DEAD);
        chk("stall_release", 70'(ME_Forward_Res), 70'h0_1234_5678);
        chk("stall_allow4", 70'(ME_Allow_in), 70'd1);
        tick;
        drive(0, '0, 1, 32'hDEAD_DEAD);
        chk("after_stall", 70'(ME_Forward_Res), 70'h0_0000_00AA);
        tick;

        // Back-to-back ALU ops
        for (int k = 1; k <= 4; k++) begin
            drive(1, mk(0, 0, 0, 2'd0, 32'h1C00_0100 + 32'(4 * k), 32'h100 * k, 0, 1, 5'(k)), 1, 32'h0);
            if (k > 1) chk("b2b_dest", 70'(ME_dest), 70'(k - 1));
            tick;
        end
        drive(0, '0, 1, 32'h0);
        chk("b2b_dest4", 70'(ME_dest), 70'd4);
        chk("b2b_res4", 70'(ME_Forward_Res), 70'h0_0000_0400);
        tick;

        // Store
        drive(1, mk(0, 0, 0, 2'd0, 32'h1C00_0200, 32'h0000_4000, 0, 0, 5'd12), 1, 32'h0);
        tick;
        drive(0, '0, 1, 32'h0);
        chk("st_valid", 70'(ME_to_WB_Valid), 70'd1);
        chk("st_dest", 70'(ME_dest), 70'd0);
        chk("st_ldop", 70'(ME_to_ID_Ld_op), 70'd0);
        chk("st_we", 70'(ME_to_WB_Bus[5]), 70'd0);
        tick;

        // Async reset mid-stall
        drive(1, mk(0, 0, 0, 2'd0, 32'h1C00_0300, 32'h0000_5000, 1, 1, 5'd7), 1, 32'h0);
        tick;
        drive(0, '0, 0, 32'hCAFE_F00D);
        chk("pre_rst_valid", 70'(ME_to_WB_Valid), 70'd1);
        chk("pre_rst_ldop", 70'(ME_to_ID_Ld_op), 70'd1);
        tick;
        drive(0, '0, 0, 32'h0BAD_0BAD);
        reset = 1'b1;
        #1;
        chk("arst_valid", 70'(ME_to_WB_Valid), 70'd0);
        chk("arst_allow", 70'(ME_Allow_in), 70'd1);
        chk("arst_dest", 70'(ME_dest), 70'd0);
        chk("arst_ldop", 70'(ME_to_ID_Ld_op), 70'd0);
        tick;
        reset = 1'b0;
        drive(0, '0, 1, 32'h0);
        chk("post_rst_valid", 70'(ME_to_WB_Valid), 70'd0);
        tick;
        drive(1, mk(0, 0, 0, 2'd0, 32'h1C00_0400, 32'h0000_6000, 1, 1, 5'd8), 1, 32'h0);
        tick;
        drive(0, '0, 1, 32'h55AA_00FF);
        chk("post_rst_load", 70'(ME_Forward_Res), 70'h0_55AA_00FF);
        tick;
        drive(0, '0, 1, 32'h0);
        tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
